// File: rtl/iob_gpio_sonar_ctrl.sv
`default_nettype none
// iob_gpio_sonar_ctrl -- round-robin trigger/echo sequencer for ultrasonic ranging channels.
// Rev 1.0: initial release.
module iob_gpio_sonar_ctrl #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [CNT_W-1:0] trig_len,
  input  logic [CNT_W-1:0] timeout,
  input  logic [CNT_W-1:0] holdoff,
  input  logic [N_CH-1:0]  echo_in,
  output logic [N_CH-1:0]  trig_out,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res_ch,
  output logic [CNT_W-1:0] res_width,
  output logic             res_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_TRIG, S_WAIT_RISE, S_MEASURE, S_REPORT, S_HOLDOFF
  } state_t;

  state_t           state, state_nxt;
  logic [N_CH-1:0]  echo_m, echo_s, trig_nxt;
  logic [2:0]       last, cur_ch, sel_ch, sel_lo, sel_hi, ch_nxt;
  logic             hi_found, echo_sel, load_res, to_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, trig_len_eff, width_nxt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      echo_m <= '0;
      echo_s <= '0;
    end else begin
      echo_m <= echo_in;
      echo_s <= echo_m;
    end
  end

  // Descending scan leaves the lowest set bit overall and the lowest set bit above last.
  always_comb begin
    sel_lo   = '0;
    sel_hi   = '0;
    hi_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        sel_lo = 3'(i);
        if (3'(i) > last) begin
          sel_hi   = 3'(i);
          hi_found = 1'b1;
        end
      end
    end
    sel_ch = hi_found ? sel_hi : sel_lo;
  end

  always_comb begin
    echo_sel = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (3'(i) == cur_ch) echo_sel = echo_s[i];
    end
  end

  assign ch_nxt       = (state == S_SELECT) ? sel_ch : cur_ch;
  assign cnt_inc      = cnt + CNT_W'(1);
  assign trig_len_eff = (trig_len == '0) ? CNT_W'(1) : trig_len;
  assign busy         = (state != S_IDLE);

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      trig_nxt[i] = (state_nxt == S_TRIG) && (3'(i) == ch_nxt);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_res  = 1'b0;
    width_nxt = cnt;
    to_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && (ch_mask != '0)) state_nxt = S_SELECT;
      end
      S_SELECT: begin
        cnt_nxt   = '0;
        state_nxt = (!enable || (ch_mask == '0)) ? S_IDLE : S_TRIG;
      end
      S_TRIG: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (cnt_inc >= trig_len_eff) begin
          state_nxt = S_WAIT_RISE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_WAIT_RISE: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (echo_sel) begin
          state_nxt = S_MEASURE;
          cnt_nxt   = CNT_W'(1);
        end else if (cnt_inc >= timeout) begin
          state_nxt = S_REPORT;
          load_res  = 1'b1;
          width_nxt = '0;
          to_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_MEASURE: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (!echo_sel) begin
          state_nxt = S_REPORT;
          load_res  = 1'b1;
          width_nxt = cnt;
        end else if (cnt >= timeout) begin
          // Saturate at the limit rather than let the count wrap.
          state_nxt = S_REPORT;
          load_res  = 1'b1;
          width_nxt = timeout;
          to_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          cnt_nxt = '0;
          if (!enable)               state_nxt = S_IDLE;
          else if (holdoff != '0)    state_nxt = S_HOLDOFF;
          else                       state_nxt = S_SELECT;
        end
      end
      S_HOLDOFF: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (cnt_inc >= holdoff) begin
          state_nxt = S_SELECT;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last        <= 3'(N_CH - 1);
      cur_ch      <= '0;
      trig_out    <= '0;
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_width   <= '0;
      res_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      trig_out <= trig_nxt;
      if ((state == S_SELECT) && (state_nxt == S_TRIG)) begin
        cur_ch <= sel_ch;
        last   <= sel_ch;
      end
      if (load_res) begin
        res_valid   <= 1'b1;
        res_ch      <= cur_ch;
        res_width   <= width_nxt;
        res_timeout <= to_nxt;
      end else if ((state == S_REPORT) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_gpio_sonar_ctrl.sv
`default_nettype none
// tb_iob_gpio_sonar_ctrl -- directed tests against a transaction-level echo/result model.
module tb_iob_gpio_sonar_ctrl;
  localparam int N_CH  = 8;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [2:0]       ch;
    logic [CNT_W-1:0] w;
    logic             to;
  } res_t;

  logic             clk = 1'b0;
  logic             arst_n = 1'b1;
  logic             enable = 1'b0;
  logic             res_ready = 1'b1;
  logic [N_CH-1:0]  ch_mask = '0;
  logic [CNT_W-1:0] trig_len = 16'd10;
  logic [CNT_W-1:0] timeout = 16'd1000;
  logic [CNT_W-1:0] holdoff = '0;
  logic [N_CH-1:0]  echo_resp = '0;
  logic [N_CH-1:0]  echo_stuck = '0;
  logic [N_CH-1:0]  echo_in;
  logic [N_CH-1:0]  trig_out;
  logic             busy, res_valid, res_timeout;
  logic [2:0]       res_ch;
  logic [CNT_W-1:0] res_width;

  assign echo_in = echo_resp | echo_stuck;

  iob_gpio_sonar_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .ch_mask(ch_mask),
    .trig_len(trig_len), .timeout(timeout), .holdoff(holdoff), .echo_in(echo_in),
    .trig_out(trig_out), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_ch(res_ch), .res_width(res_width), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  int   checks = 0, failures = 0, cyc = 0;
  int   ch_q[$];
  res_t res_q[$];
  int   hist[$];
  int   resp_d[N_CH], resp_w[N_CH];
  int   n_trig = 0, n_vrise = 0, n_results = 0;
  int   last_ch = -1, last_w = -1, last_to = -1, last_pulse = -1, last_lat = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N_CH-1:0] v);
    for (int i = 0; i < N_CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Echo responder and result predictor: when a trigger ends, echo after a delay
  // and predict the measurement from the configured echo shape.
  initial begin : responder
    logic [N_CH-1:0] prev;
    int   ch;
    res_t r;
    prev = '0;
    forever begin
      @(posedge clk); #1;
      if (arst_n && (prev != '0) && (trig_out == '0)) begin
        ch   = oh_idx(prev);
        r.ch = 3'(ch);
        if (echo_stuck[ch]) begin
          r.w = timeout; r.to = 1'b1;
        end else if ((resp_w[ch] == 0) || (resp_d[ch] + 3 > int'(timeout))) begin
          r.w = '0; r.to = 1'b1;
        end else if (resp_w[ch] > int'(timeout)) begin
          r.w = timeout; r.to = 1'b1;
        end else begin
          r.w = CNT_W'(resp_w[ch]); r.to = 1'b0;
        end
        res_q.push_back(r);
        if ((resp_w[ch] > 0) && !echo_stuck[ch]) begin
          repeat (resp_d[ch]) @(posedge clk);
          #1 echo_resp[ch] = 1'b1;
          repeat (resp_w[ch]) @(posedge clk);
          #1 echo_resp[ch] = 1'b0;
        end
      end
      prev = trig_out;
    end
  end

  initial begin : compare
    logic [N_CH-1:0] ptrig;
    logic            pvalid;
    int              hi_len, fall_cyc, cur_exp, idx;
    ptrig = '0; pvalid = 1'b0; hi_len = 0; fall_cyc = 0; cur_exp = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!arst_n) begin
        ptrig = '0; pvalid = 1'b0; hi_len = 0;
      end else begin
        chk("trig_onehot", int'($onehot0(trig_out)), 1);
        idx = oh_idx(trig_out);
        if ((trig_out != '0) && (ptrig == '0)) begin
          n_trig++;
          hi_len = 1;
          checks++;
          if (ch_q.size() == 0) begin
            failures++;
            cur_exp = -1;
            $display("FAIL trig_ch: trigger on ch %0d, expected no trigger", idx);
          end else begin
            cur_exp = ch_q.pop_front();
            if (idx != cur_exp) begin
              failures++;
              $display("FAIL trig_ch: got ch %0d, expected ch %0d", idx, cur_exp);
            end
          end
        end else if (trig_out != '0) begin
          hi_len++;
          chk("trig_ch_hold", idx, cur_exp);
        end else if (ptrig != '0) begin
          chk("trig_len", hi_len, (trig_len == '0) ? 1 : int'(trig_len));
          last_pulse = hi_len;
          fall_cyc   = cyc;
        end
        if (res_valid) begin
          if (!pvalid) begin
            n_vrise++;
            last_lat = cyc - fall_cyc;
          end
          checks++;
          if (res_q.size() == 0) begin
            failures++;
            $display("FAIL res_unexpected: res_valid high with ch %0d width %0d, expected none",
                     res_ch, res_width);
          end else begin
            chk("res_ch", int'(res_ch), int'(res_q[0].ch));
            chk("res_width", int'(res_width), int'(res_q[0].w));
            chk("res_timeout", int'(res_timeout), int'(res_q[0].to));
            if (res_ready) begin
              void'(res_q.pop_front());
              last_ch = int'(res_ch); last_w = int'(res_width); last_to = int'(res_timeout);
              hist.push_back(int'(res_ch));
              n_results++;
            end
          end
        end
      end
      ptrig  = trig_out;
      pvalid = res_valid;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    arst_n = 1'b0; enable = 1'b0; res_ready = 1'b1; echo_stuck = '0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    ch_q.delete(); res_q.delete(); hist.delete();
  endtask

  task automatic wait_valid(input int k, input bit drop, input string name);
    int seen = 0, t = 0;
    bit pv = 1'b0;
    while ((seen < k) && (t < 5000)) begin
      @(posedge clk); #1;
      t++;
      if (res_valid && !pv) begin
        seen++;
        if ((seen == k) && drop) enable = 1'b0;
      end
      pv = res_valid;
    end
    if (seen < k) begin
      checks++; failures++;
      $display("FAIL %s_wait: saw %0d results, expected %0d", name, seen, k);
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && (t < 2000)) begin
      @(posedge clk); #1;
      t++;
    end
    chk(name, int'(busy), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int exp_rr[5];
    int v0, t, r0;
    exp_rr = '{0, 2, 5, 7, 0};
    for (int i = 0; i < N_CH; i++) begin resp_d[i] = 3; resp_w[i] = 5; end

    // Power-on reset values
    #1 arst_n = 1'b0;
    #2;
    chk("rst_trig", int'(trig_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_ch", int'(res_ch), 0);
    chk("rst_width", int'(res_width), 0);
    chk("rst_timeout", int'(res_timeout), 0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;

    // Asynchronous reset in the middle of a trigger pulse
    ch_mask = 8'h01; trig_len = 16'd10; timeout = 16'd1000; holdoff = '0;
    resp_d[0] = 20; resp_w[0] = 100;
    ch_q.push_back(0);
    enable = 1'b1;
    t = 0;
    while ((trig_out == '0) && (t < 100)) begin @(posedge clk); #1; t++; end
    chk("midtrig_started", int'(trig_out), 1);
    repeat (3) @(posedge clk);
    #3 arst_n = 1'b0;
    #1;
    chk("midtrig_rst_trig", int'(trig_out), 0);
    chk("midtrig_rst_busy", int'(busy), 0);
    chk("midtrig_rst_valid", int'(res_valid), 0);
    enable = 1'b0;
    do_reset();

    // Normal measurement: 20-cycle echo delay, 100-cycle echo
    ch_mask = 8'h01; trig_len = 16'd10; timeout = 16'd1000; holdoff = '0; res_ready = 1'b1;
    ch_q.push_back(0);
    enable = 1'b1;
    wait_valid(1, 1'b1, "normal");
    wait_idle("normal_idle");
    chk("normal_ch", last_ch, 0);
    chk("normal_width", last_w, 100);
    chk("normal_timeout", last_to, 0);
    chk("normal_pulse", last_pulse, 10);
    chk("normal_trig_seen", ch_q.size(), 0);
    do_reset();

    // No echo; trig_len 0 behaves as a 1-cycle pulse
    ch_mask = 8'h04; trig_len = '0; timeout = 16'd50; resp_w[2] = 0;
    ch_q.push_back(2);
    enable = 1'b1;
    wait_valid(1, 1'b1, "noecho");
    wait_idle("noecho_idle");
    chk("noecho_ch", last_ch, 2);
    chk("noecho_width", last_w, 0);
    chk("noecho_timeout", last_to, 1);
    chk("noecho_latency", last_lat, 50);
    chk("noecho_pulse", last_pulse, 1);
    resp_w[2] = 5;
    do_reset();

    // Stuck-high echo saturates at timeout
    echo_stuck[1] = 1'b1;
    ch_mask = 8'h02; trig_len = 16'd4; timeout = 16'd50;
    ch_q.push_back(1);
    enable = 1'b1;
    wait_valid(1, 1'b1, "stuck");
    wait_idle("stuck_idle");
    chk("stuck_ch", last_ch, 1);
    chk("stuck_width", last_w, 50);
    chk("stuck_timeout", last_to, 1);
    do_reset();

    // Round-robin scan across 0xA5
    for (int i = 0; i < N_CH; i++) begin resp_d[i] = 3; resp_w[i] = 5; end
    ch_mask = 8'hA5; trig_len = 16'd3; timeout = 16'd200; holdoff = 16'd2;
    foreach (exp_rr[i]) ch_q.push_back(exp_rr[i]);
    enable = 1'b1;
    wait_valid(5, 1'b1, "rr");
    wait_idle("rr_idle");
    chk("rr_count", hist.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < hist.size()) chk($sformatf("rr_order%0d", i), hist[i], exp_rr[i]);
    end
    chk("rr_trig_seen", ch_q.size(), 0);
    do_reset();

    // Backpressure: result held, no new trigger while blocked
    ch_mask = 8'h02; trig_len = 16'd5; timeout = 16'd100; holdoff = '0;
    resp_d[1] = 2; resp_w[1] = 7;
    res_ready = 1'b0;
    ch_q.push_back(1);
    enable = 1'b1;
    wait_valid(1, 1'b0, "bp");
    v0 = n_trig; r0 = n_results;
    repeat (30) @(posedge clk);
    #1;
    chk("bp_valid_held", int'(res_valid), 1);
    chk("bp_ch", int'(res_ch), 1);
    chk("bp_width", int'(res_width), 7);
    chk("bp_timeout", int'(res_timeout), 0);
    chk("bp_no_trigger", n_trig, v0);
    enable = 1'b0;
    res_ready = 1'b1;
    wait_idle("bp_idle");
    chk("bp_delivered", n_results, r0 + 1);
    chk("bp_trig_seen", ch_q.size(), 0);
    do_reset();

    // Abort during MEASURE: idle next cycle, no result
    ch_mask = 8'h08; trig_len = 16'd5; timeout = 16'd1000;
    resp_d[3] = 3; resp_w[3] = 200;
    ch_q.push_back(3);
    v0 = n_vrise;
    enable = 1'b1;
    t = 0;
    while (!echo_resp[3] && (t < 200)) begin @(posedge clk); #1; t++; end
    chk("abort_echo_started", int'(echo_resp[3]), 1);
    repeat (10) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_trig", int'(trig_out), 0);
    repeat (220) @(posedge clk);
    #1;
    chk("abort_no_valid", n_vrise, v0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
